pfft_mul_rr_scheduler: RTL and testbench

//  - Time-shares one 28x28 unsigned multiplier (55-bit product) among NUM_REQ FFT butterfly requesters.
//  - Round-robin grant, at most one issue per cycle; the product is tagged with the requester index.
//  - Sits between the posit mantissa-multiply stages and the shared multiplier resource.

---
 rtl/pfft_mul_rr_scheduler.sv | 177 +++++++++++++++++
 tb/tb_pfft_mul_rr_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pfft_mul_rr_scheduler.sv
// pfft_mul_rr_scheduler
//
// Time-shares one DIN_W x DIN_W unsigned multiplier among NUM_REQ FFT butterfly requesters.
// A round-robin arbiter picks at most one requester per cycle. The low DOUT_W bits of the
// product travel down a PIPE-deep register pipeline, tagged with the index of the requester.
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst     in   asynchronous reset, active-high
//   stall      in   freeze: no grant, pipeline and pointer hold
//   req_valid  in   [NUM_REQ]        per-requester operand valid
//   req_ready  out  [NUM_REQ]        one-hot grant, combinational from valid, pointer and stall
//   req_a      in   [NUM_REQ*DIN_W]  flat operand A, slice i belongs to requester i
//   req_b      in   [NUM_REQ*DIN_W]  flat operand B
//   res_valid  out  product valid (no backpressure)
//   res_id     out  [ID_W]           requester index of the product
//   res_data   out  [DOUT_W]         product, low DOUT_W bits
//
// Optional build macro PFFT_MUL_SCHED_STATS_EN adds:
//   stat_busy  out  [32]  issue count, wraps
//   stat_stall out  [32]  cycles with stall=1 while any req_valid=1, saturating
module pfft_mul_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DIN_W   = 28,
  parameter int unsigned DOUT_W  = 55,
  parameter int unsigned PIPE    = 2,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic                       stall,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DIN_W-1:0]   req_a,
  input  logic [NUM_REQ*DIN_W-1:0]   req_b,
  output logic                       res_valid,
  output logic [ID_W-1:0]            res_id,
  output logic [DOUT_W-1:0]          res_data
`ifdef PFFT_MUL_SCHED_STATS_EN
  ,
  output logic [31:0]                stat_busy,
  output logic [31:0]                stat_stall
`endif
);

  // Round-robin pointer: index with highest priority this cycle.
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               found;
  logic               issue;
  int                 idx;

  // Search from ptr upward, wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(NUM_REQ)) begin
        idx = idx - int'(NUM_REQ);
      end
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

  assign req_ready = (ap_rst || stall) ? '0 : grant;
  assign issue     = |(req_valid & req_ready);

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // Operand mux: grant is one-hot, so an OR of masked slices suffices.
  logic [DIN_W-1:0]    sel_a, sel_b;
  logic [2*DIN_W-1:0]  prod_full;
  logic [DOUT_W-1:0]   prod;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        sel_a = sel_a | req_a[i*DIN_W +: DIN_W];
        sel_b = sel_b | req_b[i*DIN_W +: DIN_W];
      end
    end
  end

  assign prod_full = {{DIN_W{1'b0}}, sel_a} * {{DIN_W{1'b0}}, sel_b};
  assign prod      = prod_full[DOUT_W-1:0];

  // Result pipeline: stage 0 captures the product, later stages only shift.
  logic [PIPE-1:0]   vld_q, vld_d;
  logic [ID_W-1:0]   id_q   [PIPE];
  logic [ID_W-1:0]   id_d   [PIPE];
  logic [DOUT_W-1:0] data_q [PIPE];
  logic [DOUT_W-1:0] data_d [PIPE];

  always_comb begin
    vld_d  = vld_q;
    id_d   = id_q;
    data_d = data_q;
    if (!stall) begin
      vld_d[0]  = issue;
      id_d[0]   = grant_idx;
      data_d[0] = prod;
      for (int s = 1; s < int'(PIPE); s++) begin
        vld_d[s]  = vld_q[s-1];
        id_d[s]   = id_q[s-1];
        data_d[s] = data_q[s-1];
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr_q <= '0;
      vld_q <= '0;
      for (int s = 0; s < int'(PIPE); s++) begin
        id_q[s]   <= '0;
        data_q[s] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      for (int s = 0; s < int'(PIPE); s++) begin
        id_q[s]   <= id_d[s];
        data_q[s] <= data_d[s];
      end
    end
  end

  assign res_valid = vld_q[PIPE-1];
  assign res_id    = id_q[PIPE-1];
  assign res_data  = data_q[PIPE-1];

`ifdef PFFT_MUL_SCHED_STATS_EN
  logic [31:0] stat_busy_q, stat_busy_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_busy_d  = stat_busy_q;
    stat_stall_d = stat_stall_q;
    if (issue) begin
      stat_busy_d = stat_busy_q + 32'd1;
    end
    if (stall && (|req_valid) && (stat_stall_q != '1)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stat_busy_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_busy_q  <= stat_busy_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_busy  = stat_busy_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_pfft_mul_rr_scheduler.sv
// Directed, table-driven bench for pfft_mul_rr_scheduler (NUM_REQ=4, DIN_W=28, DOUT_W=55, PIPE=2).
// Requester i receives operand a+i and operand b for the vector's (a, b) pair.
module tb_pfft_mul_rr_scheduler;

  localparam int NR = 4;
  localparam int DW = 28;
  localparam int OW = 55;

  logic           ap_clk = 1'b0;
  logic           ap_rst;
  logic           stall;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*DW-1:0] req_a, req_b;
  logic           res_valid;
  logic [1:0]     res_id;
  logic [OW-1:0]  res_data;
`ifdef PFFT_MUL_SCHED_STATS_EN
  logic [31:0]    stat_busy, stat_stall;
  logic [31:0]    busy0;
`endif

  pfft_mul_rr_scheduler #(
    .NUM_REQ(NR),
    .DIN_W  (DW),
    .DOUT_W (OW),
    .PIPE   (2)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .stall    (stall),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .res_valid(res_valid),
    .res_id   (res_id),
    .res_data (res_data)
`ifdef PFFT_MUL_SCHED_STATS_EN
    ,
    .stat_busy (stat_busy),
    .stat_stall(stat_stall)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic          stall;
    logic [3:0]    valid;
    logic [27:0]   a;
    logic [27:0]   b;
    logic [3:0]    exp_ready;
    logic          exp_rv;
    logic [1:0]    exp_id;
    logic [54:0]   exp_data;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic st, logic [3:0] v, logic [27:0] a, logic [27:0] b,
                              logic [3:0] rdy, logic rv, logic [1:0] id, logic [54:0] d);
    vec_t t;
    t.stall = st; t.valid = v; t.a = a; t.b = b;
    t.exp_ready = rdy; t.exp_rv = rv; t.exp_id = id; t.exp_data = d;
    return t;
  endfunction

  task automatic drive(logic st, logic [3:0] v, logic [27:0] a, logic [27:0] b);
    stall     = st;
    req_valid = v;
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = a + 28'(i);
      req_b[i*DW +: DW] = b;
    end
  endtask

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    // Columns: stall, valid, a, b, exp_ready, exp_res_valid, exp_res_id, exp_res_data
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));                      // 0 idle
    tbl.push_back(mk(0, 4'b0010, 2, 5, 4'b0010, 0, 0, 0));                      // 1 req1 3*5
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 1, 1, 55'd15));                 // 3
    tbl.push_back(mk(0, 4'b0001, 28'hFFFFFFF, 28'hFFFFFFF, 4'b0001, 0, 0, 0));  // 4 max
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 1, 0, 55'h7FFFFFE0000001));     // 6
    tbl.push_back(mk(0, 4'b1000, 1, 1, 4'b1000, 0, 0, 0));                      // 7 ptr -> 0
    tbl.push_back(mk(0, 4'b1111, 10, 3, 4'b0001, 0, 0, 0));                     // 8 rotation
    tbl.push_back(mk(0, 4'b1111, 10, 3, 4'b0010, 1, 3, 55'd4));
    tbl.push_back(mk(0, 4'b1111, 10, 3, 4'b0100, 1, 0, 55'd30));
    tbl.push_back(mk(0, 4'b1111, 10, 3, 4'b1000, 1, 1, 55'd33));
    tbl.push_back(mk(0, 4'b1111, 10, 3, 4'b0001, 1, 2, 55'd36));
    tbl.push_back(mk(0, 4'b1111, 10, 3, 4'b0010, 1, 3, 55'd39));
    tbl.push_back(mk(0, 4'b1111, 10, 3, 4'b0100, 1, 0, 55'd30));
    tbl.push_back(mk(0, 4'b1111, 10, 3, 4'b1000, 1, 1, 55'd33));
    tbl.push_back(mk(1, 4'b1111, 10, 3, 4'b0000, 1, 2, 55'd36));                // 16 stall x3
    tbl.push_back(mk(1, 4'b1111, 10, 3, 4'b0000, 1, 2, 55'd36));
    tbl.push_back(mk(1, 4'b1111, 10, 3, 4'b0000, 1, 2, 55'd36));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 1, 2, 55'd36));                 // 19 resume
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 1, 3, 55'd39));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 5, 7, 4'b0100, 0, 0, 0));                      // 22 ptr -> 3
    tbl.push_back(mk(0, 4'b0101, 5, 7, 4'b0001, 0, 0, 0));                      // 23 wrap to 0
    tbl.push_back(mk(0, 4'b0100, 5, 7, 4'b0100, 1, 2, 55'd49));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 1, 0, 55'd35));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 1, 2, 55'd49));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 2, 5, 4'b0010, 0, 0, 0));                      // 28 single req
    tbl.push_back(mk(0, 4'b0010, 2, 5, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 2, 5, 4'b0010, 1, 1, 55'd15));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 1, 1, 55'd15));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 1, 1, 55'd15));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));

    // Reset state, with requests pending to show ready is masked.
    ap_rst = 1'b1;
    drive(0, 4'b1111, 10, 3);
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_ready", -1, 64'(req_ready), 64'd0);
    chk("rst_valid", -1, 64'(res_valid), 64'd0);
    chk("rst_id",    -1, 64'(res_id),    64'd0);
    chk("rst_data",  -1, 64'(res_data),  64'd0);
    ap_rst = 1'b0;
    drive(0, 4'b0000, 0, 0);
    @(posedge ap_clk);
    #1;

    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n].stall, tbl[n].valid, tbl[n].a, tbl[n].b);
      #6;
      chk("req_ready", n, 64'(req_ready), 64'(tbl[n].exp_ready));
      chk("res_valid", n, 64'(res_valid), 64'(tbl[n].exp_rv));
      if (tbl[n].exp_rv) begin
        chk("res_id",   n, 64'(res_id),   64'(tbl[n].exp_id));
        chk("res_data", n, 64'(res_data), 64'(tbl[n].exp_data));
      end
`ifdef PFFT_MUL_SCHED_STATS_EN
      if (n == 19) chk("stat_stall", n, 64'(stat_stall), 64'd3);
      if (n == 22) busy0 = stat_busy;
      if (n == 24) chk("stat_busy_delta", n, 64'(stat_busy - busy0), 64'd2);
`endif
      @(posedge ap_clk);
      #1;
    end

    // Mid-operation reset: two issues in flight (ptr=2 here, so reqs 2 then 3).
    drive(0, 4'b1111, 10, 3);
    repeat (2) @(posedge ap_clk);
    #1;
    chk("pre_rst_valid", 100, 64'(res_valid), 64'd1);
    chk("pre_rst_id",    100, 64'(res_id),    64'd2);
    ap_rst = 1'b1;
    #1;
    chk("mid_rst_valid", 101, 64'(res_valid), 64'd0);
    chk("mid_rst_data",  101, 64'(res_data),  64'd0);
    chk("mid_rst_ready", 101, 64'(req_ready), 64'd0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    #1;
    chk("post_rst_grant", 102, 64'(req_ready), 64'b0001);
    @(posedge ap_clk);
    #1;
    chk("post_rst_grant2", 103, 64'(req_ready), 64'b0010);
    chk("post_rst_flushed", 103, 64'(res_valid), 64'd0);
    drive(0, 4'b0000, 0, 0);
    @(posedge ap_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
